// File: rtl/frame_sched.sv
// frame_sched: round-robin scheduler that hands one shared frame transmitter
// to one of four requesters at a time. It issues the winner's command, waits
// for the transmitter to go busy and then idle again, pulses done (or err on
// timeout) and enforces an idle gap before the next frame.
module frame_sched #(
    parameter logic [15:0] GAP_CYC = 16'd16,
    parameter logic [15:0] TMO_CYC = 16'hFFFF
) (
    input  logic        ck,
    input  logic        rstn,
    input  logic [3:0]  req,
    input  logic [15:0] cmd_in,
    input  logic        tx_busy,
    output logic [3:0]  tx_cmd,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  ptr_r, ptr_s;
    logic [1:0]  win_r, win_s;
    logic [3:0]  cmd_r, cmd_s;
    logic [15:0] timer_r, timer_s;
    logic [15:0] gap_cnt_r, gap_cnt_s;

    logic [3:0]  elig_s;
    logic        found_s;
    logic [1:0]  pick_s;
    logic [1:0]  idx_s;
    logic [3:0]  pick_cmd_s;
    logic        tmo_hit_s;
    logic        gap_last_s;

    logic [3:0]  tx_cmd_s;
    logic [3:0]  gnt_s;
    logic [3:0]  done_s;
    logic        err_s;

    // A requester only counts when it asks and carries a non-zero command.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig_s[i] = req[i] && (cmd_in[4*i +: 4] != 4'h0);
        end
    end

    // Round-robin search starting at ptr; first eligible index wins.
    always_comb begin
        found_s = 1'b0;
        pick_s  = ptr_r;
        idx_s   = ptr_r;
        for (int k = 0; k < 4; k++) begin
            idx_s = ptr_r + 2'(k);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
                pick_s  = pick_s;
            end
        end
    end

    // Command nibble belonging to the current search winner.
    always_comb begin
        pick_cmd_s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (pick_s == 2'(i)) begin
                pick_cmd_s = cmd_in[4*i +: 4];
            end else begin
                pick_cmd_s = pick_cmd_s;
            end
        end
    end

    // Timer/gap terminal conditions; the gap always lasts at least one cycle.
    always_comb begin
        tmo_hit_s  = ({1'b0, timer_r} + 17'd1) >= {1'b0, TMO_CYC};
        gap_last_s = (GAP_CYC == 16'd0) ||
                     (({1'b0, gap_cnt_r} + 17'd1) >= {1'b0, GAP_CYC});
    end

    // FSM state register.
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a done in WAIT outranks a simultaneous timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!tx_busy && found_s) state_s = ST_ISSUE;
                else                     state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (tx_busy)        state_s = ST_WAIT;
                else if (tmo_hit_s) state_s = ST_GAP;
                else                state_s = ST_ISSUE;
            end
            ST_WAIT: begin
                if (!tx_busy)       state_s = ST_GAP;
                else if (tmo_hit_s) state_s = ST_GAP;
                else                state_s = ST_WAIT;
            end
            ST_GAP: begin
                if (gap_last_s) state_s = ST_IDLE;
                else            state_s = ST_GAP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and the frame bookkeeping.
    always_comb begin
        tx_cmd_s  = tx_cmd;
        gnt_s     = gnt;
        done_s    = 4'h0;
        err_s     = 1'b0;
        ptr_s     = ptr_r;
        win_s     = win_r;
        cmd_s     = cmd_r;
        timer_s   = timer_r;
        gap_cnt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (!tx_busy && found_s) begin
                    win_s    = pick_s;
                    cmd_s    = pick_cmd_s;
                    tx_cmd_s = pick_cmd_s;
                    gnt_s    = 4'b0001 << pick_s;
                    timer_s  = 16'd0;
                end else begin
                    tx_cmd_s = 4'h0;
                    gnt_s    = 4'h0;
                end
            end
            ST_ISSUE: begin
                if (tx_busy) begin
                    tx_cmd_s = 4'h0;
                    timer_s  = 16'd0;
                end else if (tmo_hit_s) begin
                    err_s     = 1'b1;
                    tx_cmd_s  = 4'h0;
                    gnt_s     = 4'h0;
                    ptr_s     = win_r + 2'd1;
                    gap_cnt_s = 16'd0;
                end else begin
                    tx_cmd_s = cmd_r;
                    timer_s  = timer_r + 16'd1;
                end
            end
            ST_WAIT: begin
                tx_cmd_s = 4'h0;
                if (!tx_busy) begin
                    done_s    = 4'b0001 << win_r;
                    gnt_s     = 4'h0;
                    ptr_s     = win_r + 2'd1;
                    gap_cnt_s = 16'd0;
                end else if (tmo_hit_s) begin
                    err_s     = 1'b1;
                    gnt_s     = 4'h0;
                    ptr_s     = win_r + 2'd1;
                    gap_cnt_s = 16'd0;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            ST_GAP: begin
                tx_cmd_s = 4'h0;
                gnt_s    = 4'h0;
                if (gap_last_s) gap_cnt_s = 16'd0;
                else            gap_cnt_s = gap_cnt_r + 16'd1;
            end
            default: begin
                tx_cmd_s = 4'h0;
                gnt_s    = 4'h0;
            end
        endcase
    end

    // Output and bookkeeping registers; reset clears everything at once.
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            tx_cmd    <= 4'h0;
            gnt       <= 4'h0;
            done      <= 4'h0;
            err       <= 1'b0;
            ptr_r     <= 2'd0;
            win_r     <= 2'd0;
            cmd_r     <= 4'h0;
            timer_r   <= 16'd0;
            gap_cnt_r <= 16'd0;
        end else begin
            tx_cmd    <= tx_cmd_s;
            gnt       <= gnt_s;
            done      <= done_s;
            err       <= err_s;
            ptr_r     <= ptr_s;
            win_r     <= win_s;
            cmd_r     <= cmd_s;
            timer_r   <= timer_s;
            gap_cnt_r <= gap_cnt_s;
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// Testbench for frame_sched: scenario tasks with inline checks against a
// round-robin reference model kept in the bench.
module tb_frame_sched;

    logic        ck = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [15:0] cmd_in;
    logic        tx_busy;
    logic [3:0]  tx_cmd, gnt, done;
    logic        err;
    logic [3:0]  g0_tx_cmd, g0_gnt, g0_done;
    logic        g0_err;

    int checks   = 0;
    int failures = 0;

    always #5 ck = ~ck;

    frame_sched #(.GAP_CYC(16'd16), .TMO_CYC(16'd100)) dut (
        .ck(ck), .rstn(rstn), .req(req), .cmd_in(cmd_in), .tx_busy(tx_busy),
        .tx_cmd(tx_cmd), .gnt(gnt), .done(done), .err(err)
    );

    frame_sched #(.GAP_CYC(16'd0), .TMO_CYC(16'd100)) dut_g0 (
        .ck(ck), .rstn(rstn), .req(req), .cmd_in(cmd_in), .tx_busy(tx_busy),
        .tx_cmd(g0_tx_cmd), .gnt(g0_gnt), .done(g0_done), .err(g0_err)
    );

    // Reference rule: search p, p+1, p+2, p+3 mod 4; first eligible wins.
    function automatic int pick(input int p, input logic [3:0] r, input logic [15:0] c);
        int w = -1;
        for (int k = 0; k < 4; k++) begin
            int i = (p + k) % 4;
            if (w < 0 && r[i] && c[4*i +: 4] != 4'h0) w = i;
        end
        return w;
    endfunction

    function automatic logic [3:0] rand_nz();
        return 4'($urandom_range(15, 1));
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req = 4'h0; cmd_in = 16'h0; tx_busy = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        rstn = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(input int bound, output int n);
        n = 0;
        while (gnt === 4'h0 && n < bound) begin
            tick();
            n++;
        end
        if (gnt === 4'h0) n = -1;
    endtask

    task automatic finish_frame(input int dly, input int len, output logic [3:0] cs,
                                output logic [3:0] ds, output logic es);
        repeat (dly) tick();
        cs = tx_cmd;
        tx_busy = 1'b1;
        repeat (len) tick();
        tx_busy = 1'b0;
        tick();
        ds = done;
        es = err;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 4'h0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (tx_cmd !== 4'h0) begin failures++; $display("FAIL reset_tx_cmd got=%h exp=0", tx_cmd); end
        checks++; if (done !== 4'h0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_single();
        int bad = 0;
        int n = 0;
        do_reset();
        cmd_in = 16'h0009; req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001 || tx_cmd !== 4'h9) begin failures++; $display("FAIL single_grant gnt=%b cmd=%h exp 0001/9", gnt, tx_cmd); end
        tick(); tick();
        checks++; if (tx_cmd !== 4'h9) begin failures++; $display("FAIL single_hold_cmd got=%h exp=9", tx_cmd); end
        tx_busy = 1'b1;
        tick();
        checks++; if (tx_cmd !== 4'h0 || gnt !== 4'b0001) begin failures++; $display("FAIL single_busy_seen cmd=%h gnt=%b exp 0/0001", tx_cmd, gnt); end
        repeat (59) begin
            tick();
            if (done !== 4'h0 || err !== 1'b0 || gnt !== 4'b0001) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL single_wait_stable bad_cycles=%0d exp=0", bad); end
        tx_busy = 1'b0;
        tick();
        checks++; if (done !== 4'b0001 || gnt !== 4'h0) begin failures++; $display("FAIL single_done done=%b gnt=%b exp 0001/0000", done, gnt); end
        tick();
        checks++; if (done !== 4'h0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0000", done); end
        while (gnt === 4'h0 && n < 40) begin tick(); n++; end
        checks++; if (n != 16 || gnt !== 4'b0001) begin failures++; $display("FAIL single_gap cycles=%0d gnt=%b exp 16/0001", n, gnt); end
    endtask

    task automatic test_round_robin();
        int p = 0;
        int w, n;
        logic [15:0] c;
        logic [3:0] cs, ds, ec;
        logic es;
        do_reset();
        for (int i = 0; i < 4; i++) c[4*i +: 4] = rand_nz();
        cmd_in = c; req = 4'hF;
        for (int f = 0; f < 5; f++) begin
            w = pick(p, req, cmd_in);
            wait_gnt(60, n);
            checks++; if (n < 0 || gnt !== (4'b0001 << w)) begin failures++; $display("FAIL rr_gnt frame=%0d got=%b exp=%b", f, gnt, 4'(4'b0001 << w)); end
            ec = c[4*w +: 4];
            finish_frame(int'($urandom_range(4, 0)), int'($urandom_range(30, 1)), cs, ds, es);
            checks++; if (cs !== ec) begin failures++; $display("FAIL rr_cmd frame=%0d got=%h exp=%h", f, cs, ec); end
            checks++; if (ds !== (4'b0001 << w) || es !== 1'b0) begin failures++; $display("FAIL rr_done frame=%0d done=%b err=%b exp=%b/0", f, ds, es, 4'(4'b0001 << w)); end
            p = (w + 1) % 4;
        end
    endtask

    task automatic test_zero_cmd();
        int n;
        logic [3:0] cs, ds;
        logic es;
        do_reset();
        req = 4'b0011; cmd_in = 16'h0090;
        for (int f = 0; f < 3; f++) begin
            wait_gnt(60, n);
            checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL zero_gnt frame=%0d got=%b exp=0010", f, gnt); end
            finish_frame(1, 3, cs, ds, es);
            checks++; if (ds !== 4'b0010) begin failures++; $display("FAIL zero_done frame=%0d got=%b exp=0010", f, ds); end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int bad = 0;
        do_reset();
        req = 4'b0100; cmd_in = 16'h0500;
        tick();
        checks++; if (gnt !== 4'b0100 || tx_cmd !== 4'h5) begin failures++; $display("FAIL tmo_grant gnt=%b cmd=%h exp 0100/5", gnt, tx_cmd); end
        while (err !== 1'b1 && n < 150) begin tick(); n++; if (done !== 4'h0) bad++; end
        checks++; if (n != 100 || bad != 0) begin failures++; $display("FAIL tmo_issue_cycles got=%0d done_bad=%0d exp 100/0", n, bad); end
        checks++; if (tx_cmd !== 4'h0 || gnt !== 4'h0 || done !== 4'h0) begin failures++; $display("FAIL tmo_outputs cmd=%h gnt=%b done=%b exp 0", tx_cmd, gnt, done); end
        req = 4'hF; cmd_in = 16'h1234;
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse got=%b exp=0", err); end
        wait_gnt(60, n);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL tmo_ptr_adv got=%b exp=1000", gnt); end
        tx_busy = 1'b1;
        tick();
        n = 0;
        while (err !== 1'b1 && n < 150) begin tick(); n++; end
        checks++; if (n != 100 || gnt !== 4'h0 || done !== 4'h0) begin failures++; $display("FAIL tmo_wait cycles=%0d gnt=%b done=%b exp 100/0/0", n, gnt, done); end
        tx_busy = 1'b0;
        wait_gnt(60, n);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL tmo_ptr_wrap got=%b exp=0001", gnt); end
        tx_busy = 1'b1;
        tick();
        repeat (99) tick();
        tx_busy = 1'b0;
        tick();
        checks++; if (done !== 4'b0001 || err !== 1'b0) begin failures++; $display("FAIL tmo_done_wins done=%b err=%b exp 0001/0", done, err); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_no_late_err got=%b exp=0", err); end
    endtask

    task automatic test_busy_idle();
        int bad = 0;
        do_reset();
        tx_busy = 1'b1; req = 4'b0100; cmd_in = 16'h0300;
        repeat (10) begin
            tick();
            if (gnt !== 4'h0 || tx_cmd !== 4'h0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL busy_idle_nogrant bad_cycles=%0d exp=0", bad); end
        tx_busy = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0100 || tx_cmd !== 4'h3) begin failures++; $display("FAIL busy_idle_grant gnt=%b cmd=%h exp 0100/3", gnt, tx_cmd); end
    endtask

    task automatic test_reset_mid();
        int n;
        int bad = 0;
        logic [3:0] cs, ds;
        logic es;
        do_reset();
        req = 4'b0100; cmd_in = 16'h0700;
        wait_gnt(10, n);
        finish_frame(1, 5, cs, ds, es);
        checks++; if (ds !== 4'b0100) begin failures++; $display("FAIL rstmid_first_done got=%b exp=0100", ds); end
        wait_gnt(60, n);
        tx_busy = 1'b1;
        tick(); tick();
        #2 rstn = 1'b0;
        #1;
        checks++; if (gnt !== 4'h0 || tx_cmd !== 4'h0 || done !== 4'h0 || err !== 1'b0) begin failures++; $display("FAIL rstmid_async gnt=%b cmd=%h done=%b err=%b exp 0", gnt, tx_cmd, done, err); end
        repeat (3) begin
            @(posedge ck); #1;
            if (gnt !== 4'h0 || tx_cmd !== 4'h0 || done !== 4'h0 || err !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_hold bad_cycles=%0d exp=0", bad); end
        rstn = 1'b1; tx_busy = 1'b0; req = 4'b1010; cmd_in = 16'h5050;
        tick();
        checks++; if (gnt !== 4'b0010 || tx_cmd !== 4'h5) begin failures++; $display("FAIL rstmid_regrant gnt=%b cmd=%h exp 0010/5", gnt, tx_cmd); end
    endtask

    task automatic test_random();
        int p = 0;
        int w, n;
        logic [3:0] r, cs, ds, ec;
        logic [15:0] c;
        logic es;
        do_reset();
        for (int f = 0; f < 14; f++) begin
            r = 4'($urandom_range(15, 0));
            for (int i = 0; i < 4; i++) c[4*i +: 4] = ($urandom_range(3, 0) == 0) ? 4'h0 : rand_nz();
            req = r; cmd_in = c;
            w = pick(p, r, c);
            if (w < 0) begin
                wait_gnt(40, n);
                checks++; if (n != -1) begin failures++; $display("FAIL rand_nogrant frame=%0d gnt=%b exp=0000", f, gnt); end
            end else begin
                wait_gnt(60, n);
                checks++; if (n < 0 || gnt !== (4'b0001 << w)) begin failures++; $display("FAIL rand_gnt frame=%0d got=%b exp=%b", f, gnt, 4'(4'b0001 << w)); end
                ec = c[4*w +: 4];
                req = 4'($urandom_range(15, 0));
                cmd_in = 16'($urandom_range(65535, 0));
                finish_frame(int'($urandom_range(5, 0)), int'($urandom_range(40, 1)), cs, ds, es);
                checks++; if (cs !== ec) begin failures++; $display("FAIL rand_cmd frame=%0d got=%h exp=%h", f, cs, ec); end
                checks++; if (ds !== (4'b0001 << w) || es !== 1'b0) begin failures++; $display("FAIL rand_done frame=%0d done=%b err=%b exp=%b/0", f, ds, es, 4'(4'b0001 << w)); end
                p = (w + 1) % 4;
            end
        end
    endtask

    task automatic test_gap0();
        do_reset();
        req = 4'b0001; cmd_in = 16'h000A;
        tick();
        checks++; if (g0_gnt !== 4'b0001 || g0_tx_cmd !== 4'hA) begin failures++; $display("FAIL gap0_grant gnt=%b cmd=%h exp 0001/a", g0_gnt, g0_tx_cmd); end
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        checks++; if (g0_done !== 4'b0001 || g0_err !== 1'b0) begin failures++; $display("FAIL gap0_done done=%b err=%b exp 0001/0", g0_done, g0_err); end
        tick();
        checks++; if (g0_gnt !== 4'h0) begin failures++; $display("FAIL gap0_gap got=%b exp=0000", g0_gnt); end
        tick();
        checks++; if (g0_gnt !== 4'b0001) begin failures++; $display("FAIL gap0_regrant got=%b exp=0001", g0_gnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_cmd();
        test_timeout();
        test_busy_idle();
        test_reset_mid();
        test_random();
        test_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
